// File: rtl/led_scan_display_n.sv
// Multiplexed 7-segment scan driver for NUM_DIGITS common-anode digits with frame-synchronous
// image update, PWM brightness, dead time, per-digit blink and leading-zero blanking.
module led_scan_display_n #(
   parameter int NUM_DIGITS     = 6,
   parameter int SCAN_DIV       = 25000,
   parameter int DEAD_CYCLES    = 64,
   parameter int BLINK_FRAMES   = 64,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [4*NUM_DIGITS-1:0] upd_digits,
   input  logic [NUM_DIGITS-1:0]   upd_dp,
   input  logic [NUM_DIGITS-1:0]   upd_blink,
   input  logic                    upd_lzb,
   input  logic [3:0]              brightness,
   output logic [NUM_DIGITS-1:0]   SEL,
   output logic [7:0]              DIG,
   output logic                    frame_start
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(1'b0);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0]      IDX_ZERO = IDX_W'(1'b0);
   localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam logic [BLK_W-1:0]      BLK_ZERO = BLK_W'(1'b0);
   localparam logic [31:0]           ON_SPAN  = 32'(SCAN_DIV - DEAD_CYCLES);
   localparam logic [31:0]           DEAD_W   = 32'(DEAD_CYCLES);
   localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1'b1);

   function automatic logic [7:0] seg_decode(input logic [3:0] nib, input logic dp);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         4'hF:    seg = 8'h8E;
         default: seg = 8'hFF;
      endcase
      seg[7] = ~dp;
      return seg;
   endfunction

   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        idx_r;
   logic [31:0]             on_len_r;
   logic [BLK_W-1:0]        blk_cnt_r;
   logic                    phase_r;
   logic                    rdy_r;
   logic [4*NUM_DIGITS-1:0] pend_dig_r, act_dig_r;
   logic [NUM_DIGITS-1:0]   pend_dp_r, act_dp_r, pend_blink_r, act_blink_r;
   logic                    pend_lzb_r, act_lzb_r;
   logic [NUM_DIGITS-1:0]   sel_r;
   logic [7:0]              dig_r;
   logic                    fs_r;

   logic                    slot_end_s, boundary_s, accept_s, on_s, blank_s, zrun_s;
   logic [31:0]             on_new_s, on_len_s, cnt32_s;
   logic [NUM_DIGITS-1:0]   lz_s, sel_n_s;
   logic [7:0]              dig_n_s;
   logic [3:0]              nib_s;

   // Slot/frame timing, on-window length for the current slot, handshake decision
   always_comb begin
      slot_end_s = (cnt_r == CNT_LAST);
      boundary_s = slot_end_s && (idx_r == IDX_LAST);
      accept_s   = upd_valid && rdy_r;
      on_new_s   = (ON_SPAN * (32'd1 + 32'(brightness))) >> 4;
      cnt32_s    = 32'(cnt_r);
      if (cnt_r == CNT_ZERO) begin
         on_len_s = on_new_s;
      end else begin
         on_len_s = on_len_r;
      end
      on_s = (cnt32_s >= DEAD_W) && (cnt32_s < (DEAD_W + on_len_s));
   end

   // Leading-zero mask: digit i blanks when it and every digit above it are zero
   always_comb begin
      lz_s   = {NUM_DIGITS{1'b0}};
      zrun_s = act_lzb_r;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zrun_s  = zrun_s && (act_dig_r[4*i +: 4] == 4'h0);
         lz_s[i] = zrun_s;
      end
   end

   // Next SEL/DIG/frame_start values from the current scan position and active image
   always_comb begin
      nib_s   = act_dig_r[4*idx_r +: 4];
      blank_s = (act_blink_r[idx_r] && !phase_r) || lz_s[idx_r];
      if (on_s) begin
         sel_n_s = SEL_ACTIVE_LOW ? ~(ONE_HOT0 << idx_r) : (ONE_HOT0 << idx_r);
         if (blank_s) begin
            dig_n_s = 8'hFF;
         end else begin
            dig_n_s = seg_decode(nib_s, act_dp_r[idx_r]);
         end
      end else begin
         sel_n_s = SEL_IDLE;
         dig_n_s = 8'hFF;
      end
   end

   // Scan counters; brightness is frozen for the slot at its first cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= CNT_ZERO;
         idx_r    <= IDX_ZERO;
         on_len_r <= 32'd0;
      end else begin
         if (cnt_r == CNT_ZERO) begin
            on_len_r <= on_new_s;
         end
         if (slot_end_s) begin
            cnt_r <= CNT_ZERO;
            idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_W'(1'b1));
         end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end
      end
   end

   // Shadow image: capture on handshake, promote to active only at the frame boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_r        <= 1'b1;
         pend_dig_r   <= {(4*NUM_DIGITS){1'b0}};
         pend_dp_r    <= {NUM_DIGITS{1'b0}};
         pend_blink_r <= {NUM_DIGITS{1'b0}};
         pend_lzb_r   <= 1'b0;
         act_dig_r    <= {(4*NUM_DIGITS){1'b0}};
         act_dp_r     <= {NUM_DIGITS{1'b0}};
         act_blink_r  <= {NUM_DIGITS{1'b0}};
         act_lzb_r    <= 1'b0;
      end else begin
         if (boundary_s && !rdy_r) begin
            act_dig_r   <= pend_dig_r;
            act_dp_r    <= pend_dp_r;
            act_blink_r <= pend_blink_r;
            act_lzb_r   <= pend_lzb_r;
         end
         if (accept_s) begin
            pend_dig_r   <= upd_digits;
            pend_dp_r    <= upd_dp;
            pend_blink_r <= upd_blink;
            pend_lzb_r   <= upd_lzb;
            rdy_r        <= 1'b0;
         end else if (boundary_s) begin
            rdy_r <= 1'b1;
         end
      end
   end

   // Blink phase toggles every BLINK_FRAMES frame boundaries
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt_r <= BLK_ZERO;
         phase_r   <= 1'b1;
      end else if (boundary_s) begin
         if (blk_cnt_r == BLK_LAST) begin
            blk_cnt_r <= BLK_ZERO;
            phase_r   <= ~phase_r;
         end else begin
            blk_cnt_r <= blk_cnt_r + BLK_W'(1'b1);
         end
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_r <= SEL_IDLE;
         dig_r <= 8'hFF;
         fs_r  <= 1'b0;
      end else begin
         sel_r <= sel_n_s;
         dig_r <= dig_n_s;
         fs_r  <= (cnt_r == CNT_ZERO) && (idx_r == IDX_ZERO);
      end
   end

   assign SEL         = sel_r;
   assign DIG         = dig_r;
   assign frame_start = fs_r;
   assign upd_ready   = rdy_r;

endmodule
